qpu_exu_moitf: RTL and testbench
================================

Name: qpu_exu_moitf

Overview:
- Measurement outstanding-instruction tracking FIFO (MOITF) in the QPU execute unit.
- Records the qubit list of every measure instruction the dispatch stage issues, and holds a per-qubit pending mask until the measurement results return.
- Gives dispatch the qubit-flag dependency check (measure/FMR against in-flight measurements) and the MOITF-ready signal.
- Retires entries in order and reports each completed qubit list to the QMR update logic.

Parameters:
- DEPTH, 4, number of entries; power of two, at least 2.
- QUBIT_NUM, `QPU_QUBIT_NUM, width of qubit list and masks.
- PTR_W, $clog2(DEPTH), pointer width (derived; not to be overridden).
- TIMEOUT_CYC, 1023, watchdog limit in cycles (used only with the optional feature).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- flush  in  1  synchronous clear of all entries
- disp_moitf_ena  in  1  allocate an entry (measure dispatched this cycle)
- disp_moitf_ready  out  1  free entry available
- disp_oitf_qfren  in  1  dispatching instruction reads qubit flags
- disp_oitf_qubitlist  in  QUBIT_NUM  qubit list of the dispatching instruction
- oitfqf_match_dispql  out  1  qubit-list overlap with in-flight measurements
- mres_valid  in  1  measurement results returning this cycle
- mres_qubit  in  QUBIT_NUM  qubits whose result returns this cycle
- moitf_ret_valid  out  1  head entry retires this cycle
- moitf_ret_qubitlist  out  QUBIT_NUM  original qubit list of the retiring entry
- moitf_busy_vec  out  QUBIT_NUM  OR of pending masks of all valid entries
- moitf_empty  out  1  no valid entries
- moitf_timeout  out  1  sticky watchdog error (0 when the optional feature is out)

Behaviour:
- State per entry:
  - vld bit;
  - qlist[QUBIT_NUM], the original list;
  - pend[QUBIT_NUM], the outstanding qubits.
- Global state: wptr, rptr, cnt in 0..DEPTH.
- Reset (rst=1 at a clock edge): all vld=0, pend=0, wptr=rptr=cnt=0, timeout=0.
  - Outputs after reset: ready=1, empty=1, busy_vec=0, match=0, ret_valid=0.
  - Reset mid-operation discards all pending entries without signalling retirement.
- flush: same effect as reset, except moitf_timeout is held. flush has priority over alloc, result and retire in the same cycle.
- disp_moitf_ready = (cnt != DEPTH), registered state only. There is no same-cycle pass-through from a retire.
- Alloc: when disp_moitf_ena=1 and ready=1:
  - entry[wptr] gets vld=1, qlist=pend=disp_oitf_qubitlist;
  - wptr = wptr+1, wrapping modulo DEPTH.
  - disp_moitf_ena=1 while full is ignored and is an assertion failure.
- busy_vec = OR over valid entries of pend, from registered state.
- oitfqf_match_dispql = disp_oitf_qfren & |(disp_oitf_qubitlist & busy_vec).
  - Combinational with no result bypass: a result arriving in cycle t unblocks dispatch in cycle t+1.
- Result: when mres_valid=1, every entry valid before the edge gets pend &= ~mres_qubit.
  - An entry allocated in the same cycle is not affected.
  - Bits for qubits not pending are ignored; an assertion flags them.
  - Pending masks are disjoint across entries, guaranteed by the dispatch qf dependency check.
- Retire:
  - moitf_ret_valid = vld[rptr] & (pend[rptr]==0), combinational from state.
  - moitf_ret_qubitlist = qlist[rptr].
  - On that edge: vld[rptr]=0, rptr = rptr+1 (wrap).
  - At most one retirement per cycle.
  - A younger entry that has completed waits until it reaches the head.
- Latency:
  - Result in cycle t gives retire pulse in t+1 at the earliest.
  - An entry allocated with an empty qubit list retires in the cycle after allocation.
- cnt update: +1 on alloc only, -1 on retire only, unchanged when both happen.
  - Alloc and retire in the same cycle is legal whenever cnt < DEPTH.
- moitf_empty = (cnt==0).

Optional Feature:
- Macro: QPU_MOITF_TIMEOUT_EN.
- Defined:
  - A head-age counter clears on every retire or alloc into an empty FIFO, and increments while the head is valid and not retiring.
  - When the counter reaches TIMEOUT_CYC, the head is force-retired next cycle: ret_valid=1, pend cleared.
  - moitf_timeout is set and stays set until rst.
- Not defined: no counter logic; moitf_timeout tied to 0.

Decomposition:
- Shared defines header, alongside existing QPU defines: QPU_QUBIT_NUM, QPU_MOITF_DEPTH default, QPU_MOITF_TIMEOUT_CYC.
- One natural sub-module: qpu_moitf_entry. It holds vld/qlist/pend for one entry, with alloc, clear-mask and retire inputs. The top module instantiates DEPTH of them.

Test Plan:
- Reset then alloc qlist=0b0011 → next cycle busy_vec=0b0011. Dispatch qfren=1, qlist=0b0010 → match=1. qfren=0 → match=0.
- mres_qubit=0b0001 then 0b0010 on consecutive cycles → ret_valid=1 with ret_qubitlist=0b0011 exactly one cycle after the second result; empty=1 the following cycle.
- Fill 4 entries (0x1,0x2,0x4,0x8) → ready=0; ena while full → state unchanged. Return result 0x8 first → no retire until 0x1,0x2,0x4 complete; retire order 0x1,0x2,0x4,0x8.
- Full FIFO with head retiring and ena=1 in the same cycle → alloc rejected, cnt=3 afterwards. Next cycle alloc is accepted and wptr wraps to the freed slot.
- flush asserted together with ena and mres_valid → all entries cleared, empty=1, no ret_valid; rst mid-operation gives the same result.
- With QPU_MOITF_TIMEOUT_EN and TIMEOUT_CYC=8: alloc 0x4 with no result → forced ret_valid after 8 cycles, timeout=1 sticky. Without the macro → entry stays indefinitely and timeout=0.

Source files
------------

// File: rtl/qpu_exu_moitf_pkg.sv
// qpu_exu_moitf_pkg: shared QPU defines and MOITF configuration defaults.
`ifndef QPU_QUBIT_NUM
`define QPU_QUBIT_NUM 4
`endif
`ifndef QPU_MOITF_DEPTH
`define QPU_MOITF_DEPTH 4
`endif
`ifndef QPU_MOITF_TIMEOUT_CYC
`define QPU_MOITF_TIMEOUT_CYC 1023
`endif

package qpu_exu_moitf_pkg;
  localparam int MOITF_QUBIT_NUM   = `QPU_QUBIT_NUM;
  localparam int MOITF_DEPTH       = `QPU_MOITF_DEPTH;
  localparam int MOITF_TIMEOUT_CYC = `QPU_MOITF_TIMEOUT_CYC;
  function automatic logic moitf_is_pow2(input int n);
    return (n >= 2) && ((n & (n - 1)) == 0);
  endfunction
endpackage

// File: rtl/qpu_moitf_entry.sv
// qpu_moitf_entry: one MOITF slot holding valid bit, original qubit list and pending mask.
module qpu_moitf_entry #(
  parameter int QUBIT_NUM = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr_i,
  input  logic                 alloc_i,
  input  logic [QUBIT_NUM-1:0] qlist_i,
  input  logic                 mres_valid_i,
  input  logic [QUBIT_NUM-1:0] mres_qubit_i,
  input  logic                 ret_i,
  output logic                 vld_o,
  output logic [QUBIT_NUM-1:0] qlist_o,
  output logic [QUBIT_NUM-1:0] pend_o
);
  logic                 vld_q, vld_d;
  logic [QUBIT_NUM-1:0] qlist_q, qlist_d, pend_q, pend_d;
  // a result only clears entries that were already valid before this edge
  always_comb begin
    vld_d   = clr_i ? 1'b0 : alloc_i ? 1'b1 : ret_i ? 1'b0 : vld_q;
    qlist_d = (alloc_i && !clr_i) ? qlist_i : qlist_q;
    pend_d  = clr_i ? '0 : alloc_i ? qlist_i : ret_i ? '0 :
              (mres_valid_i && vld_q) ? (pend_q & ~mres_qubit_i) : pend_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q   <= 1'b0;
      qlist_q <= '0;
      pend_q  <= '0;
    end else begin
      vld_q   <= vld_d;
      qlist_q <= qlist_d;
      pend_q  <= pend_d;
    end
  end
  assign vld_o   = vld_q;
  assign qlist_o = qlist_q;
  assign pend_o  = pend_q;
endmodule

// File: rtl/qpu_exu_moitf.sv
// qpu_exu_moitf: in-order measurement outstanding-instruction FIFO with per-qubit pending tracking.
// QPU_MOITF_TIMEOUT_EN adds the head-age watchdog; QPU_MOITF_ASSERT_EN enables protocol checks.
module qpu_exu_moitf
  import qpu_exu_moitf_pkg::*;
#(
  parameter int DEPTH       = MOITF_DEPTH,
  parameter int QUBIT_NUM   = MOITF_QUBIT_NUM,
  parameter int PTR_W       = $clog2(DEPTH),
  parameter int TIMEOUT_CYC = MOITF_TIMEOUT_CYC
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 disp_moitf_ena,
  output logic                 disp_moitf_ready,
  input  logic                 disp_oitf_qfren,
  input  logic [QUBIT_NUM-1:0] disp_oitf_qubitlist,
  output logic                 oitfqf_match_dispql,
  input  logic                 mres_valid,
  input  logic [QUBIT_NUM-1:0] mres_qubit,
  output logic                 moitf_ret_valid,
  output logic [QUBIT_NUM-1:0] moitf_ret_qubitlist,
  output logic [QUBIT_NUM-1:0] moitf_busy_vec,
  output logic                 moitf_empty,
  output logic                 moitf_timeout
);
  logic [PTR_W-1:0]     wptr_q, wptr_d, rptr_q, rptr_d;
  logic [PTR_W:0]       cnt_q, cnt_d;
  logic [DEPTH-1:0]     vld;
  logic [QUBIT_NUM-1:0] qlist [DEPTH];
  logic [QUBIT_NUM-1:0] pend  [DEPTH];
  logic                 alloc, ret, force_ret;
  if (!moitf_is_pow2(DEPTH) || TIMEOUT_CYC < 1) begin : g_bad_cfg
    $error("qpu_exu_moitf: DEPTH must be a power of two >= 2 and TIMEOUT_CYC >= 1");
  end
  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    qpu_moitf_entry #(.QUBIT_NUM(QUBIT_NUM)) u_ent (
      .clk          (clk),
      .rst          (rst),
      .clr_i        (flush),
      .alloc_i      (alloc && wptr_q == PTR_W'(i)),
      .qlist_i      (disp_oitf_qubitlist),
      .mres_valid_i (mres_valid),
      .mres_qubit_i (mres_qubit),
      .ret_i        (ret && rptr_q == PTR_W'(i)),
      .vld_o        (vld[i]),
      .qlist_o      (qlist[i]),
      .pend_o       (pend[i])
    );
  end
  assign disp_moitf_ready    = cnt_q != (PTR_W+1)'(DEPTH);
  assign moitf_empty         = cnt_q == '0;
  assign alloc               = disp_moitf_ena && disp_moitf_ready;
  // reset and flush discard entries silently, so no retire pulse in those cycles
  assign ret                 = vld[rptr_q] && (pend[rptr_q] == '0 || force_ret) && !flush && !rst;
  assign moitf_ret_valid     = ret;
  assign moitf_ret_qubitlist = qlist[rptr_q];
  assign oitfqf_match_dispql = disp_oitf_qfren && |(disp_oitf_qubitlist & moitf_busy_vec);
  always_comb begin
    moitf_busy_vec = '0;
    for (int i = 0; i < DEPTH; i++) moitf_busy_vec = moitf_busy_vec | (vld[i] ? pend[i] : '0);
  end
  always_comb begin
    wptr_d = flush ? '0 : wptr_q + PTR_W'(alloc);
    rptr_d = flush ? '0 : rptr_q + PTR_W'(ret);
    cnt_d  = flush ? '0 : cnt_q + (PTR_W+1)'(alloc) - (PTR_W+1)'(ret);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end
`ifdef QPU_MOITF_TIMEOUT_EN
  localparam int AGE_W = $clog2(TIMEOUT_CYC + 1);
  logic [AGE_W-1:0] age_q, age_d;
  logic             timeout_q;
  assign force_ret = vld[rptr_q] && age_q == AGE_W'(TIMEOUT_CYC);
  assign age_d     = (flush || ret || (alloc && moitf_empty)) ? '0 :
                     (vld[rptr_q] && !force_ret) ? age_q + 1'b1 : age_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      age_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      age_q     <= age_d;
      timeout_q <= timeout_q || (ret && force_ret && pend[rptr_q] != '0);
    end
  end
  assign moitf_timeout = timeout_q;
`else
  assign force_ret     = 1'b0;
  assign moitf_timeout = 1'b0;
`endif
`ifdef QPU_MOITF_ASSERT_EN
  always_ff @(posedge clk) begin
    if (!rst && !flush) begin
      assert (!(disp_moitf_ena && !disp_moitf_ready)) else $error("moitf: alloc while full");
      assert (!mres_valid || (mres_qubit & ~moitf_busy_vec) == '0) else $error("moitf: result for non-pending qubit");
    end
  end
`endif
endmodule

// File: tb/tb_qpu_exu_moitf.sv
// tb_qpu_exu_moitf: directed vector table plus random traffic against a queue-based reference model.
module tb_qpu_exu_moitf;
  import qpu_exu_moitf_pkg::*;
  localparam int QN   = MOITF_QUBIT_NUM;
  localparam int D    = 4;
  localparam int TCYC = 8;
  typedef logic [QN-1:0] q_t;
  typedef struct {
    logic r, fl, ena, qf;
    q_t   ql;
    logic mv;
    q_t   mq;
    logic rdy, emp;
    q_t   busy;
    logic mt, rv;
    q_t   rql;
  } vec_t;
  typedef struct {
    q_t ql, pend;
  } ent_t;

  logic clk = 1'b0, rst = 1'b1, flush = 1'b0, ena = 1'b0, qfren = 1'b0, mv = 1'b0;
  q_t   ql = '0, mq = '0;
  logic ready, match, rv, empty, tmo;
  q_t   rql, busy;
  ent_t model[$];
  vec_t tab[$];
  int   n_chk = 0, n_fail = 0;

  qpu_exu_moitf #(.DEPTH(D), .QUBIT_NUM(QN), .TIMEOUT_CYC(TCYC)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .flush               (flush),
    .disp_moitf_ena      (ena),
    .disp_moitf_ready    (ready),
    .disp_oitf_qfren     (qfren),
    .disp_oitf_qubitlist (ql),
    .oitfqf_match_dispql (match),
    .mres_valid          (mv),
    .mres_qubit          (mq),
    .moitf_ret_valid     (rv),
    .moitf_ret_qubitlist (rql),
    .moitf_busy_vec      (busy),
    .moitf_empty         (empty),
    .moitf_timeout       (tmo)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic q_t m_busy();
    q_t b = '0;
    foreach (model[i]) b |= model[i].pend;
    return b;
  endfunction

  function automatic vec_t mk(input logic r, fl, e, qf, input q_t l, input logic m, input q_t mqv,
                              input logic rdy, emp, input q_t b, input logic mt, rvv, input q_t rl);
    vec_t v;
    v.r = r; v.fl = fl; v.ena = e; v.qf = qf; v.ql = l; v.mv = m; v.mq = mqv;
    v.rdy = rdy; v.emp = emp; v.busy = b; v.mt = mt; v.rv = rvv; v.rql = rl;
    return v;
  endfunction

  task automatic step(input vec_t v, input bit use_tab);
    logic m_rdy, m_rv;
    vec_t e;
    rst = v.r; flush = v.fl; ena = v.ena; qfren = v.qf; ql = v.ql; mv = v.mv; mq = v.mq;
    #1;
    m_rdy = model.size() != D;
    m_rv  = !v.r && !v.fl && model.size() > 0 && model[0].pend == '0;
    e = v;
    if (!use_tab) begin
      e.rdy = m_rdy; e.emp = model.size() == 0; e.busy = m_busy();
      e.mt = v.qf && |(v.ql & e.busy); e.rv = m_rv; e.rql = model.size() > 0 ? model[0].ql : '0;
    end
    chk("ready", ready, e.rdy);
    chk("empty", empty, e.emp);
    chk("busy_vec", busy, e.busy);
    chk("match", match, e.mt);
    chk("ret_valid", rv, e.rv);
    if (e.rv) chk("ret_qubitlist", rql, e.rql);
    chk("timeout", tmo, 1'b0);
    @(posedge clk);
    if (v.r || v.fl) model.delete();
    else begin
      if (v.mv) foreach (model[i]) model[i].pend &= ~v.mq;
      if (m_rv) void'(model.pop_front());
      if (v.ena && m_rdy) model.push_back('{v.ql, v.ql});
    end
    @(negedge clk);
  endtask

  initial begin
    vec_t v;
    //                r  f  e  qf ql     mv mq      rdy emp busy  mt rv rql
    tab.push_back(mk(0, 0, 1, 0, 4'h3, 0, 4'h0,  1, 1, 4'h0, 0, 0, 4'h0));
    tab.push_back(mk(0, 0, 0, 1, 4'h2, 0, 4'h0,  1, 0, 4'h3, 1, 0, 4'h0));
    tab.push_back(mk(0, 0, 0, 0, 4'h2, 0, 4'h0,  1, 0, 4'h3, 0, 0, 4'h0));
    tab.push_back(mk(0, 0, 0, 0, 4'h0, 1, 4'h1,  1, 0, 4'h3, 0, 0, 4'h0));
    tab.push_back(mk(0, 0, 0, 0, 4'h0, 1, 4'h2,  1, 0, 4'h2, 0, 0, 4'h0));
    tab.push_back(mk(0, 0, 0, 0, 4'h0, 0, 4'h0,  1, 0, 4'h0, 0, 1, 4'h3));
    tab.push_back(mk(0, 0, 0, 0, 4'h0, 0, 4'h0,  1, 1, 4'h0, 0, 0, 4'h0));
    tab.push_back(mk(0, 0, 1, 0, 4'h1, 0, 4'h0,  1, 1, 4'h0, 0, 0, 4'h0));
    tab.push_back(mk(0, 0, 1, 0, 4'h2, 0, 4'h0,  1, 0, 4'h1, 0, 0, 4'h0));
    tab.push_back(mk(0, 0, 1, 0, 4'h4, 0, 4'h0,  1, 0, 4'h3, 0, 0, 4'h0));
    tab.push_back(mk(0, 0, 1, 0, 4'h8, 0, 4'h0,  1, 0, 4'h7, 0, 0, 4'h0));
    tab.push_back(mk(0, 0, 1, 0, 4'h5, 0, 4'h0,  0, 0, 4'hf, 0, 0, 4'h0));
    tab.push_back(mk(0, 0, 0, 0, 4'h0, 1, 4'h8,  0, 0, 4'hf, 0, 0, 4'h0));
    tab.push_back(mk(0, 0, 0, 0, 4'h0, 0, 4'h0,  0, 0, 4'h7, 0, 0, 4'h0));
    tab.push_back(mk(0, 0, 0, 0, 4'h0, 1, 4'h1,  0, 0, 4'h7, 0, 0, 4'h0));
    tab.push_back(mk(0, 0, 1, 0, 4'h1, 0, 4'h0,  0, 0, 4'h6, 0, 1, 4'h1));
    tab.push_back(mk(0, 0, 1, 0, 4'h1, 0, 4'h0,  1, 0, 4'h6, 0, 0, 4'h0));
    tab.push_back(mk(0, 0, 0, 0, 4'h0, 1, 4'h2,  0, 0, 4'h7, 0, 0, 4'h0));
    tab.push_back(mk(0, 0, 0, 0, 4'h0, 1, 4'h4,  0, 0, 4'h5, 0, 1, 4'h2));
    tab.push_back(mk(0, 0, 0, 0, 4'h0, 1, 4'h1,  1, 0, 4'h1, 0, 1, 4'h4));
    tab.push_back(mk(0, 0, 0, 0, 4'h0, 0, 4'h0,  1, 0, 4'h0, 0, 1, 4'h8));
    tab.push_back(mk(0, 0, 0, 0, 4'h0, 0, 4'h0,  1, 0, 4'h0, 0, 1, 4'h1));
    tab.push_back(mk(0, 0, 0, 0, 4'h0, 0, 4'h0,  1, 1, 4'h0, 0, 0, 4'h0));
    tab.push_back(mk(0, 0, 1, 0, 4'h3, 0, 4'h0,  1, 1, 4'h0, 0, 0, 4'h0));
    tab.push_back(mk(0, 0, 1, 0, 4'h4, 0, 4'h0,  1, 0, 4'h3, 0, 0, 4'h0));
    tab.push_back(mk(0, 1, 1, 0, 4'h8, 1, 4'h3,  1, 0, 4'h7, 0, 0, 4'h0));
    tab.push_back(mk(0, 0, 0, 0, 4'h0, 0, 4'h0,  1, 1, 4'h0, 0, 0, 4'h0));
    tab.push_back(mk(0, 0, 1, 0, 4'h2, 0, 4'h0,  1, 1, 4'h0, 0, 0, 4'h0));
    tab.push_back(mk(0, 0, 0, 1, 4'h1, 0, 4'h0,  1, 0, 4'h2, 0, 0, 4'h0));
    tab.push_back(mk(1, 0, 1, 0, 4'h1, 1, 4'h2,  1, 0, 4'h2, 0, 0, 4'h0));
    tab.push_back(mk(0, 0, 0, 0, 4'h0, 0, 4'h0,  1, 1, 4'h0, 0, 0, 4'h0));
    tab.push_back(mk(0, 0, 1, 0, 4'h0, 0, 4'h0,  1, 1, 4'h0, 0, 0, 4'h0));
    tab.push_back(mk(0, 0, 0, 0, 4'h0, 0, 4'h0,  1, 0, 4'h0, 0, 1, 4'h0));
    tab.push_back(mk(0, 0, 0, 0, 4'h0, 0, 4'h0,  1, 1, 4'h0, 0, 0, 4'h0));
    tab.push_back(mk(0, 0, 1, 0, 4'h4, 0, 4'h0,  1, 1, 4'h0, 0, 0, 4'h0));
    repeat (2) @(negedge clk);
    rst = 1'b0;
    foreach (tab[i]) step(tab[i], 1'b1);
    // head 0x4 never gets a result: watchdog forces it out only when enabled
    ena = 1'b0; ql = '0; qfren = 1'b0; mv = 1'b0; mq = '0;
    for (int i = 0; i < 12; i++) begin
      #1;
`ifdef QPU_MOITF_TIMEOUT_EN
      chk("wd_ret_valid", rv, i == TCYC);
      chk("wd_busy", busy, i <= TCYC ? 4'h4 : 4'h0);
      chk("wd_timeout", tmo, i > TCYC);
`else
      chk("wd_ret_valid", rv, 1'b0);
      chk("wd_busy", busy, 4'h4);
      chk("wd_timeout", tmo, 1'b0);
`endif
      @(negedge clk);
    end
    rst = 1'b1;
    @(posedge clk);
    model.delete();
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("timeout_after_rst", tmo, 1'b0);
    @(negedge clk);
    for (int n = 0; n < 400; n++) begin
      q_t b = m_busy();
      v.r   = 1'b0;
      v.fl  = $urandom_range(59) == 0;
      v.ena = model.size() != D && $urandom_range(1) == 1;
      v.ql  = q_t'($urandom) & ~b;
      v.qf  = $urandom_range(1) == 1;
      if (v.qf && $urandom_range(1) == 1) v.ql = q_t'($urandom);
      if (v.qf && v.ena) v.ql = v.ql & ~b;
      v.mv  = $urandom_range(1) == 1;
      v.mq  = q_t'($urandom) & b;
      step(v, 1'b0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
